// File: rtl/rv_iopmp_mc_scan_sequencer.sv
// rv_iopmp_mc_scan_sequencer
//   Round-robin sequencer that multiplexes NUMBER_CHANNELS request ports onto
//   one shared entry-scan engine. It walks the entry table one slice of
//   NUMBER_INSTANCES entries per cycle, stops on the first slice decision,
//   restarts the walk when the configuration changes, and returns an
//   allow/deny response on the granted channel.
//
// Ports
//   clk_i, rst_ni            clock (rising edge), async active-low reset
//   iopmp_enabled_i          0 = bypass, every request is allowed
//   cfg_changed_i            entry/MD/SRCMD written; restarts an active scan
//   req_*                    per-channel valid/ready request port
//   rsp_valid_o/rsp_ready_i  per-channel response handshake
//   rsp_allow_o              decision, qualified by rsp_valid_o
//   chk_*_o                  latched request fields and slice offset to the
//                            slice evaluator; chk_en_o while scanning
//   chk_allow_i/chk_deny_i   slice decision (allow has priority)
//   chk_err_type_i/index_i   etype and entry index of a deny
//   err_interface_o          error record, one-cycle pulse on a deny
//   busy_o                   transaction in flight

package rv_iopmp_pkg;
  typedef enum logic [1:0] {
    ACCESS_NONE      = 2'd0,
    ACCESS_READ      = 2'd1,
    ACCESS_WRITE     = 2'd2,
    ACCESS_EXECUTION = 2'd3
  } access_t;

  typedef struct packed {
    logic [2:0]  ttype;
    logic [2:0]  etype;
    logic [15:0] sid;
    logic [15:0] eid;
    logic [31:0] reqaddr;
    logic [31:0] reqaddrh;
  } error_capture_t;
endpackage

module rv_iopmp_mc_scan_sequencer #(
  parameter int ADDR_WIDTH       = 64,
  parameter int SID_WIDTH        = 8,
  parameter int NB_WIDTH         = 4,
  parameter int NUMBER_ENTRIES   = 16,
  parameter int NUMBER_INSTANCES = 4,
  parameter int NUMBER_CHANNELS  = 2
) (
  input  logic                                            clk_i,
  input  logic                                            rst_ni,
  input  logic                                            iopmp_enabled_i,
  input  logic                                            cfg_changed_i,
  input  logic [NUMBER_CHANNELS-1:0]                      req_valid_i,
  output logic [NUMBER_CHANNELS-1:0]                      req_ready_o,
  input  logic [NUMBER_CHANNELS-1:0][ADDR_WIDTH-1:0]      req_addr_i,
  input  logic [NUMBER_CHANNELS-1:0][NB_WIDTH-1:0]        req_num_bytes_i,
  input  logic [NUMBER_CHANNELS-1:0][SID_WIDTH-1:0]       req_sid_i,
  input  rv_iopmp_pkg::access_t [NUMBER_CHANNELS-1:0]     req_access_i,
  output logic [NUMBER_CHANNELS-1:0]                      rsp_valid_o,
  input  logic [NUMBER_CHANNELS-1:0]                      rsp_ready_i,
  output logic                                            rsp_allow_o,
  output logic                                            chk_en_o,
  output logic [ADDR_WIDTH-1:0]                           chk_addr_o,
  output logic [NB_WIDTH-1:0]                             chk_num_bytes_o,
  output logic [SID_WIDTH-1:0]                            chk_sid_o,
  output rv_iopmp_pkg::access_t                           chk_access_o,
  output logic [$clog2(NUMBER_ENTRIES):0]                 chk_entry_offset_o,
  input  logic                                            chk_allow_i,
  input  logic                                            chk_deny_i,
  input  logic [2:0]                                      chk_err_type_i,
  input  logic [15:0]                                     chk_err_index_i,
  output rv_iopmp_pkg::error_capture_t                    err_interface_o,
  output logic                                            busy_o
);
  import rv_iopmp_pkg::*;

  localparam int CW = (NUMBER_CHANNELS > 1) ? $clog2(NUMBER_CHANNELS) : 1;
  localparam int OW = $clog2(NUMBER_ENTRIES) + 1;
  localparam logic [OW-1:0] LAST_OFFSET = OW'(NUMBER_ENTRIES - NUMBER_INSTANCES);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESP} state_t;

  state_t               r_state, w_state_next;
  logic [CW-1:0]        r_rr_ptr, r_grant, w_gnt, w_rr_next;
  logic [OW-1:0]        r_offset, w_offset_next;
  logic                 r_allow, w_allow_next;
  error_capture_t       r_err, w_err_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [NB_WIDTH-1:0]  r_nb;
  logic [SID_WIDTH-1:0] r_sid;
  access_t              r_access;
  logic                 w_found, w_take;
  logic [2:0]           w_ttype;
  int                   w_idx;

  // Search starts at rr_ptr and wraps; the first valid channel found wins.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = 0;
    for (int i = 0; i < NUMBER_CHANNELS; i++) begin
      w_idx = int'(r_rr_ptr) + i;
      if (w_idx >= NUMBER_CHANNELS) w_idx = w_idx - NUMBER_CHANNELS;
      if (!w_found && req_valid_i[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = CW'(w_idx);
      end
    end
  end

  assign w_take    = (r_state == S_IDLE) && w_found;
  assign w_rr_next = (int'(w_gnt) == NUMBER_CHANNELS - 1) ? '0 : CW'(int'(w_gnt) + 1);

  always_comb begin
    case (r_access)
      ACCESS_WRITE:     w_ttype = 3'd2;
      ACCESS_EXECUTION: w_ttype = 3'd3;
      default:          w_ttype = 3'd1;
    endcase
  end

  always_comb begin
    w_state_next  = r_state;
    w_offset_next = r_offset;
    w_allow_next  = r_allow;
    w_err_next    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_next  = S_SCAN;
          w_offset_next = '0;
          w_allow_next  = 1'b0;
        end
      end
      S_SCAN: begin
        if (!iopmp_enabled_i) begin
          w_allow_next = 1'b1;
          w_state_next = S_RESP;
        end else if (cfg_changed_i) begin
          // Table changed under us: slice results are stale, rewalk from 0.
          w_offset_next = '0;
        end else if (chk_allow_i) begin
          w_allow_next = 1'b1;
          w_state_next = S_RESP;
        end else if (chk_deny_i || (r_offset == LAST_OFFSET)) begin
          w_allow_next        = 1'b0;
          w_state_next        = S_RESP;
          w_err_next.ttype    = w_ttype;
          w_err_next.sid      = 16'(r_sid);
          w_err_next.reqaddr  = r_addr[31:0];
          w_err_next.reqaddrh = r_addr[63:32];
          w_err_next.etype    = chk_deny_i ? chk_err_type_i : 3'h5;
          w_err_next.eid      = chk_deny_i ? chk_err_index_i : 16'h0;
        end else begin
          w_offset_next = r_offset + OW'(NUMBER_INSTANCES);
        end
      end
      S_RESP: begin
        if (rsp_ready_i[r_grant]) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_offset <= '0;
      r_allow  <= 1'b0;
      r_err    <= '0;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_addr   <= '0;
      r_nb     <= '0;
      r_sid    <= '0;
      r_access <= ACCESS_NONE;
    end else begin
      r_state  <= w_state_next;
      r_offset <= w_offset_next;
      r_allow  <= w_allow_next;
      r_err    <= w_err_next;
      if (w_take) begin
        r_grant  <= w_gnt;
        r_rr_ptr <= w_rr_next;
        r_addr   <= req_addr_i[w_gnt];
        r_nb     <= req_num_bytes_i[w_gnt];
        r_sid    <= req_sid_i[w_gnt];
        r_access <= req_access_i[w_gnt];
      end
    end
  end

  for (genvar gi = 0; gi < NUMBER_CHANNELS; gi++) begin : g_ch
    assign req_ready_o[gi] = w_take && (w_gnt == CW'(gi));
    assign rsp_valid_o[gi] = (r_state == S_RESP) && (r_grant == CW'(gi));
  end

  assign rsp_allow_o        = r_allow;
  assign chk_en_o           = (r_state == S_SCAN);
  assign chk_addr_o         = r_addr;
  assign chk_num_bytes_o    = r_nb;
  assign chk_sid_o          = r_sid;
  assign chk_access_o       = r_access;
  assign chk_entry_offset_o = r_offset;
  assign err_interface_o    = r_err;
  assign busy_o             = (r_state != S_IDLE);
endmodule

// File: doc/rv_iopmp_mc_scan_sequencer.md
# rv_iopmp_mc_scan_sequencer

Multi-channel request sequencer for the IOPMP checker. It accepts transactions from NUMBER_CHANNELS independent valid/ready request ports and grants them round-robin to one shared entry-scan engine. It walks the entry table NUMBER_INSTANCES entries per cycle, terminating early on the first slice decision, and restarts the scan when the entry configuration changes mid-walk. It returns a per-channel allow/deny response under a valid/ready handshake and raises an error-capture record on deny. It sits between the bus-side request demux and the parallel `rv_iopmp_entry` array plus `rv_iopmp_dl_wrapper` slice evaluator.

## Interface
- ADDR_WIDTH, 64, transaction address width (≥ 64 for error capture)
- SID_WIDTH, 8, source ID width
- NB_WIDTH, 4, num_bytes width
- NUMBER_ENTRIES, 16, entry table depth; must be a multiple of NUMBER_INSTANCES
- NUMBER_INSTANCES, 4, entries evaluated per cycle
- NUMBER_CHANNELS, 2, request/response channel count (≥ 1)

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active low
- iopmp_enabled_i  in  1  global enable; 0 = bypass (allow all)
- cfg_changed_i  in  1  entry/MD/SRCMD table written this cycle
- req_valid_i  in  [NUMBER_CHANNELS]  request valid per channel
- req_ready_o  out  [NUMBER_CHANNELS]  request accepted (one-hot or zero)
- req_addr_i  in  [NUMBER_CHANNELS][ADDR_WIDTH]  address
- req_num_bytes_i  in  [NUMBER_CHANNELS][NB_WIDTH]  access size
- req_sid_i  in  [NUMBER_CHANNELS][SID_WIDTH]  source ID
- req_access_i  in  [NUMBER_CHANNELS] rv_iopmp_pkg::access_t  access type
- rsp_valid_o  out  [NUMBER_CHANNELS]  response valid
- rsp_ready_i  in  [NUMBER_CHANNELS]  response accepted
- rsp_allow_o  out  1  decision, qualified by rsp_valid_o
- chk_en_o  out  1  slice evaluator enable
- chk_addr_o / chk_num_bytes_o / chk_sid_o / chk_access_o  out  latched request fields
- chk_entry_offset_o  out  $clog2(NUMBER_ENTRIES)+1  first entry index of current slice
- chk_allow_i  in  1  slice produced an allow decision
- chk_deny_i  in  1  slice produced a deny decision
- chk_err_type_i  in  3  etype for deny
- chk_err_index_i  in  16  matching entry index for deny
- err_interface_o  out  rv_iopmp_pkg::error_capture_t  error record, one-cycle pulse
- busy_o  out  1  state ≠ IDLE

## Operation
- States: IDLE, SCAN, RESP.
- IDLE:
  - Grant the lowest-numbered valid channel at or after `rr_ptr`, wrapping.
  - Assert `req_ready_o[g]` combinationally in the same cycle.
  - Latch fields and `g`; set offset = 0; go to SCAN.
  - Advance `rr_ptr` to (g+1) mod NUMBER_CHANNELS.
  - No valid request: stay in IDLE.
- SCAN: `chk_en_o` = 1. Per-cycle priority, first true wins:
  1. !iopmp_enabled_i → allow = 1, no error, go to RESP.
  2. cfg_changed_i → offset = 0, slice inputs ignored, stay in SCAN.
  3. chk_allow_i → allow = 1, go to RESP.
  4. chk_deny_i → allow = 0; error pulse with etype = chk_err_type_i, eid = chk_err_index_i; go to RESP.
  5. offset == NUMBER_ENTRIES−NUMBER_INSTANCES → allow = 0; error pulse with etype = 3'h5 (no hit), eid = 0; go to RESP.
  6. Otherwise offset += NUMBER_INSTANCES.
- RESP: `rsp_valid_o[g]` = 1, `rsp_allow_o` stable. On `rsp_ready_i[g]` go to IDLE. No new grant in the same cycle.
- Error record fields:
  - ttype: READ → 1, WRITE → 2, EXECUTION → 3, other → 1.
  - sid = latched sid.
  - reqaddr = addr[31:0], reqaddrh = addr[63:32].
  - Driven for exactly the SCAN→RESP transition cycle; all fields 0 otherwise.
- cfg_changed_i in IDLE or RESP: no effect.

## Timing
- Reset values:
  - All `req_ready_o`, `rsp_valid_o`, `rsp_allow_o`, `chk_en_o`, `busy_o` = 0.
  - `chk_*` fields = 0; access = ACCESS_NONE.
  - `err_interface_o` all 0; `rr_ptr` = 0; state = IDLE.
- Reset asserted mid-scan or mid-response: the transaction is dropped, no response is issued.
- Handshake at cycle T. Slice k is evaluated at T+1+k. `rsp_valid_o` rises at T+2+k.
- Minimum latency 2 cycles (decision in slice 0). Maximum without restarts: NUMBER_ENTRIES/NUMBER_INSTANCES + 1.
- Each restart adds 1 + slices already walked.
- Throughput: one transaction per 3 cycles minimum (IDLE, SCAN, RESP).
- `rsp_valid_o` held with a stable decision until accepted. Backpressure is unbounded.
- chk_allow_i and chk_deny_i both high: allow wins.
- All outputs except `req_ready_o` are registered or decoded from state only.

## Test plan
- Ch0 request: addr 0x8000_0000, READ, chk_allow_i in slice 0 → req_ready_o[0] at T, rsp_valid_o[0] at T+2, allow = 1, no error.
- Both channels valid continuously, every slice allows, rsp_ready_i tied 1 → grants alternate 0, 1, 0, 1; one response per 3 cycles.
- NUMBER_ENTRIES = 16, NUMBER_INSTANCES = 4, no slice decides → offsets 0, 4, 8, 12; deny at T+5.
  - Error record: etype 5, eid 0, ttype matches access, sid/addr as latched.
- chk_deny_i in slice 2 with etype 2, index 9, WRITE, sid 0x3A → deny.
  - Error pulse lasts exactly 1 cycle: ttype 2, etype 2, eid 9, sid 0x3A.
- cfg_changed_i pulsed while offset = 8 → offset returns to 0 next cycle; a subsequent allow at offset 4 yields a response 3 cycles later than without the restart.
- iopmp_enabled_i = 0 during SCAN → allow = 1 next cycle, no error. rsp_ready_i held low 5 cycles → rsp_valid_o stays high and stable. rst_ni pulsed in RESP → all outputs 0 asynchronously.
